// File: rtl/jk_reg_bank.sv
// Bank of JK flip-flops with up/down counter and toggle-mask modes; Q/WRAP/CHG registered (1 edge), TC/QN combinational.
// No flow control: every enabled edge is applied, so there is no backpressure.
module jk_reg_bank #(
  parameter int WIDTH = 8,
  parameter int SAT   = 0
) (
  input  logic             CLOCK_50,
  input  logic             RST_N,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN,
  output logic             TC,
  output logic             WRAP,
  output logic             CHG
);

  localparam logic [1:0] MODE_JK = 2'b00;
  localparam logic [1:0] MODE_UP = 2'b01;
  localparam logic [1:0] MODE_DN = 2'b10;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;
  logic             chg_nxt;

  assign QN = ~Q;

  always_comb begin
    TC = 1'b0;
    case (MODE)
      MODE_UP: TC = &Q;
      MODE_DN: TC = ~|Q;
      default: TC = 1'b0;
    endcase
  end

  // TC doubles as the "next step would wrap or saturate" condition in counter modes.
  always_comb begin
    q_nxt    = Q;
    wrap_nxt = 1'b0;
    if (LOAD) begin
      q_nxt = D;
    end else if (EN) begin
      case (MODE)
        MODE_JK: q_nxt = (J & ~Q) | (~K & Q);
        MODE_UP: begin
          if (TC) begin
            wrap_nxt = 1'b1;
            q_nxt    = (SAT != 0) ? Q : '0;
          end else begin
            q_nxt = Q + ONE;
          end
        end
        MODE_DN: begin
          if (TC) begin
            wrap_nxt = 1'b1;
            q_nxt    = (SAT != 0) ? Q : '1;
          end else begin
            q_nxt = Q - ONE;
          end
        end
        default: q_nxt = Q ^ J;
      endcase
    end
  end

  assign chg_nxt = (q_nxt != Q);

  always_ff @(posedge CLOCK_50) begin
    if (!RST_N) begin
      Q    <= '0;
      WRAP <= 1'b0;
      CHG  <= 1'b0;
    end else begin
      Q    <= q_nxt;
      WRAP <= wrap_nxt;
      CHG  <= chg_nxt;
    end
  end

endmodule

// File: tb/tb_jk_reg_bank.sv
// Scoreboard bench for jk_reg_bank: three instances (8-bit wrap, 8-bit saturate, 4-bit wrap) driven by directed vectors.
module tb_jk_reg_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] en;
  logic [2:0] load;
  logic [1:0] mode;
  logic [7:0] j, k, d;

  logic [7:0] q0, qn0, q1, qn1;
  logic [3:0] q2, qn2;
  logic       tc0, tc1, tc2, wr0, wr1, wr2, ch0, ch1, ch2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  jk_reg_bank #(.WIDTH(8), .SAT(0)) dut_wrap (
    .CLOCK_50(clk), .RST_N(rst_n), .EN(en[0]), .MODE(mode), .J(j), .K(k),
    .LOAD(load[0]), .D(d), .Q(q0), .QN(qn0), .TC(tc0), .WRAP(wr0), .CHG(ch0)
  );

  jk_reg_bank #(.WIDTH(8), .SAT(1)) dut_sat (
    .CLOCK_50(clk), .RST_N(rst_n), .EN(en[1]), .MODE(mode), .J(j), .K(k),
    .LOAD(load[1]), .D(d), .Q(q1), .QN(qn1), .TC(tc1), .WRAP(wr1), .CHG(ch1)
  );

  jk_reg_bank #(.WIDTH(4), .SAT(0)) dut_w4 (
    .CLOCK_50(clk), .RST_N(rst_n), .EN(en[2]), .MODE(mode), .J(j[3:0]), .K(k[3:0]),
    .LOAD(load[2]), .D(d[3:0]), .Q(q2), .QN(qn2), .TC(tc2), .WRAP(wr2), .CHG(ch2)
  );

  typedef struct {
    string      name;
    int         sel;
    logic [7:0] q;
    logic       wrap;
    logic       chg;
    logic       tc;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", nm, got, want);
    end
  endtask

  // Inputs change on the falling edge; the expected post-edge state is queued at the same time.
  task automatic step(input string nm, input int sel, input logic rst_i, input logic en_i,
                      input logic load_i, input logic [1:0] mode_i, input logic [7:0] j_i,
                      input logic [7:0] k_i, input logic [7:0] d_i, input logic [7:0] eq,
                      input logic ew, input logic ec, input logic etc);
    exp_t e;
    @(negedge clk);
    rst_n     = rst_i;
    mode      = mode_i;
    j         = j_i;
    k         = k_i;
    d         = d_i;
    en        = '0;
    load      = '0;
    en[sel]   = en_i;
    load[sel] = load_i;
    e.name = nm; e.sel = sel; e.q = eq; e.wrap = ew; e.chg = ec; e.tc = etc;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t       e;
    logic [7:0] gq, gqn, wqn;
    logic       gw, gc, gt;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.sel)
          0:       begin gq = q0; gqn = qn0; gw = wr0; gc = ch0; gt = tc0; wqn = ~e.q; end
          1:       begin gq = q1; gqn = qn1; gw = wr1; gc = ch1; gt = tc1; wqn = ~e.q; end
          default: begin
            gq = {4'h0, q2}; gqn = {4'h0, qn2}; gw = wr2; gc = ch2; gt = tc2;
            wqn = {4'h0, ~e.q[3:0]};
          end
        endcase
        chk({e.name, ".Q"},    gq,         e.q);
        chk({e.name, ".QN"},   gqn,        wqn);
        chk({e.name, ".WRAP"}, {7'h0, gw}, {7'h0, e.wrap});
        chk({e.name, ".CHG"},  {7'h0, gc}, {7'h0, e.chg});
        chk({e.name, ".TC"},   {7'h0, gt}, {7'h0, e.tc});
      end
    end
  end

  initial begin : stimulus
    int n;
    rst_n = 1'b0; en = '0; load = '0; mode = 2'b00; j = '0; k = '0; d = '0;

    //    name          sel rst en ld mode   J      K      D      Q      W  C  TC
    step("rst_dn",      0, 0, 0, 0, 2'b10, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 1);
    step("rst_up",      0, 0, 0, 0, 2'b01, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    step("jk_load",     0, 1, 0, 1, 2'b00, 8'h00, 8'h00, 8'h0F, 8'h0F, 0, 1, 0);
    step("jk_setclr",   0, 1, 1, 0, 2'b00, 8'hF0, 8'h0F, 8'h00, 8'hF0, 0, 1, 0);
    step("jk_toggle",   0, 1, 1, 0, 2'b00, 8'hFF, 8'hFF, 8'h00, 8'h0F, 0, 1, 0);
    step("jk_hold",     0, 1, 1, 0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h0F, 0, 0, 0);
    step("up_load",     0, 1, 1, 1, 2'b01, 8'h00, 8'h00, 8'hFE, 8'hFE, 0, 1, 0);
    step("up_ff",       0, 1, 1, 0, 2'b01, 8'h00, 8'h00, 8'h00, 8'hFF, 0, 1, 1);
    step("up_wrap",     0, 1, 1, 0, 2'b01, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 0);
    step("up_01",       0, 1, 1, 0, 2'b01, 8'h00, 8'h00, 8'h00, 8'h01, 0, 1, 0);
    step("tgl_load",    0, 1, 0, 1, 2'b11, 8'hFF, 8'h00, 8'hAA, 8'hAA, 0, 1, 0);
    step("tgl_en0",     0, 1, 0, 0, 2'b11, 8'hFF, 8'h00, 8'h00, 8'hAA, 0, 0, 0);
    step("tgl_en1",     0, 1, 1, 0, 2'b11, 8'hFF, 8'h00, 8'h00, 8'h55, 0, 1, 0);
    step("load_prio",   0, 1, 1, 1, 2'b01, 8'h00, 8'h00, 8'h3C, 8'h3C, 0, 1, 0);
    step("rst_prio",    0, 0, 1, 1, 2'b01, 8'h00, 8'h00, 8'h77, 8'h00, 0, 0, 0);
    step("dn_wrap",     0, 1, 1, 0, 2'b10, 8'h00, 8'h00, 8'h00, 8'hFF, 1, 1, 0);
    step("idle_ff",     0, 1, 0, 0, 2'b01, 8'h00, 8'h00, 8'h00, 8'hFF, 0, 0, 1);
    step("up_wrap2",    0, 1, 1, 0, 2'b01, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 0);
    step("rst_clrwrap", 0, 0, 1, 0, 2'b01, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    step("jk_tc0",      0, 1, 1, 0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);

    step("sat_load",    1, 1, 0, 1, 2'b10, 8'h00, 8'h00, 8'h01, 8'h01, 0, 1, 0);
    step("sat_dn1",     1, 1, 1, 0, 2'b10, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 1);
    step("sat_dn2",     1, 1, 1, 0, 2'b10, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 1);
    step("sat_dn3",     1, 1, 1, 0, 2'b10, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 1);
    step("sat_upld",    1, 1, 0, 1, 2'b01, 8'h00, 8'h00, 8'hFE, 8'hFE, 0, 1, 0);
    step("sat_up1",     1, 1, 1, 0, 2'b01, 8'h00, 8'h00, 8'h00, 8'hFF, 0, 1, 1);
    step("sat_up2",     1, 1, 1, 0, 2'b01, 8'h00, 8'h00, 8'h00, 8'hFF, 1, 0, 1);

    for (int i = 1; i <= 20; i++) begin
      logic [7:0] eq;
      eq = 8'(i % 16);
      step($sformatf("w4_free%0d", i), 2, 1, 1, 0, 2'b01, 8'h00, 8'h00, 8'h00,
           eq, (i == 16), 1'b1, (eq == 8'd15));
    end

    @(negedge clk);
    en = '0;
    load = '0;
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #2;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jk_reg_bank.md
JK_REG_BANK -- requirements
Module: jk_reg_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of JK flip-flops in the bank (legal range 2..32).
REQ-002 SHALL have parameter SAT, default 0: 0 = counter modes wrap, 1 = counter modes saturate.
REQ-003 SHALL have port CLOCK_50  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port RST_N  input  1  reset; one clock, reset synchronous and active-low.
REQ-005 SHALL have port EN  input  1  clock enable for JK and counter operation.
REQ-006 SHALL have port MODE  input  2  operating mode: 00 JK, 01 count up, 10 count down, 11 toggle-mask.
REQ-007 SHALL have port J  input  WIDTH  per-bit J inputs (mode 00), toggle mask (mode 11).
REQ-008 SHALL have port K  input  WIDTH  per-bit K inputs (mode 00); ignored in other modes.
REQ-009 SHALL have port LOAD  input  1  synchronous parallel load strobe.
REQ-010 SHALL have port D  input  WIDTH  parallel load data.
REQ-011 SHALL have port Q  output  WIDTH  registered bank state.
REQ-012 SHALL have port QN  output  WIDTH  bitwise complement of Q.
REQ-013 SHALL have port TC  output  1  combinational terminal count: Q all-ones in mode 01, Q all-zeros in mode 10, 0 in modes 00/11.
REQ-014 SHALL have port WRAP  output  1  registered one-cycle pulse flagging a counter wrap or saturation hit.
REQ-015 SHALL have port CHG  output  1  registered flag: Q changed value on the previous edge.

Function
REQ-016 Per-edge priority SHALL be: RST_N low > LOAD high > EN high > hold.
REQ-017 With LOAD=1, Q SHALL take D on the next edge regardless of EN and MODE.
REQ-018 Mode 00, EN=1, per bit i: J/K = 00 hold, 01 clear, 10 set, 11 toggle.
REQ-019 Mode 01, EN=1: Q SHALL become Q+1 modulo 2^WIDTH (SAT=0), or hold at all-ones (SAT=1).
REQ-020 Mode 10, EN=1: Q SHALL become Q-1 modulo 2^WIDTH (SAT=0), or hold at zero (SAT=1).
REQ-021 Mode 11, EN=1: Q SHALL become Q XOR J.
REQ-022 EN=0 and LOAD=0: Q SHALL hold; WRAP and CHG SHALL be 0 on the following cycle.
REQ-023 WRAP SHALL be 1 for exactly the cycle after an edge where EN=1, LOAD=0, and TC=1 in mode 01/10 (wrap taken or saturation blocked); else 0.
REQ-024 CHG SHALL be 1 for the cycle after any edge where Q's next value differs from its current value, including load-caused changes.
REQ-025 MODE changes SHALL take effect on the same edge; no internal mode state is kept.
REQ-026 Latency: Q, WRAP, CHG update one edge after inputs are sampled; TC and QN follow Q combinationally.
REQ-027 Counter arithmetic SHALL be WIDTH bits unsigned; no carry out beyond WRAP.

Reset
REQ-028 With RST_N=0 at an edge: Q=0, WRAP=0, CHG=0; QN therefore all-ones; TC=0 in mode 01, 1 in mode 10.
REQ-029 Reset SHALL override LOAD and EN mid-operation; the first post-reset edge operates normally from Q=0.
REQ-030 CHG SHALL NOT assert due to the reset itself.

Verification
REQ-031 WIDTH=8, mode 00, Q=0x0F, J=0xF0, K=0x0F, EN=1 -> Q=0xF0, CHG=1 next cycle; J=K=0xFF -> Q=0x0F.
REQ-032 Mode 01, SAT=0, LOAD D=0xFE, EN=1 for 3 edges -> Q=0xFF, 0x00 (WRAP=1 following cycle), 0x01; TC=1 only while Q=0xFF.
REQ-033 Mode 10, SAT=1, Q=0x01, EN=1 for 3 edges -> Q=0x00, 0x00, 0x00; WRAP=1 after the 2nd and 3rd edges; CHG=0 after the 2nd.
REQ-034 Mode 11, Q=0xAA, J=0xFF, EN=0 -> Q holds 0xAA, CHG=0; EN=1 -> Q=0x55.
REQ-035 LOAD=1 with EN=1 mode 01 D=0x3C -> Q=0x3C (not 0x3D); RST_N=0 with LOAD=1 -> Q=0x00, WRAP=0, CHG=0.
REQ-036 WIDTH=4 mode 01 SAT=0 free-run 20 edges from 0 -> Q sequence modulo 16, WRAP pulses exactly once after the 16th edge.
